// File: rtl/mc_controller.sv
// Multicycle main controller for the extended MIPS datapath (sll, zfr, li, ble).
// Moore sequencer plus a retired-instruction counter.
module mc_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             sign,
    output logic             pcen,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BLE   = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LI    = 6'b011000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_ZFR = 6'b000101;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SLL = 3'b011;
    localparam logic [2:0] ALU_ZFR = 3'b100;
    localparam logic [2:0] ALU_LI  = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_BLE     = 4'd9,
        S_ADDIEX  = 4'd10,
        S_LIEX    = 4'd11,
        S_IMMWB   = 4'd12,
        S_JUMP    = 4'd13
    } state_t;

    function automatic logic funct_known(input logic [5:0] f);
        case (f)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_ZFR: funct_known = 1'b1;
            default:                                        funct_known = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            F_ADD:   funct_alu = ALU_ADD;
            F_SUB:   funct_alu = ALU_SUB;
            F_AND:   funct_alu = ALU_AND;
            F_OR:    funct_alu = ALU_OR;
            F_SLT:   funct_alu = ALU_SLT;
            F_SLL:   funct_alu = ALU_SLL;
            F_ZFR:   funct_alu = ALU_ZFR;
            default: funct_alu = ALU_ADD;
        endcase
    endfunction

    function automatic logic instr_known(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_RTYPE:                                          instr_known = funct_known(f);
            OP_LW, OP_SW, OP_BEQ, OP_BLE, OP_ADDI, OP_LI, OP_J: instr_known = 1'b1;
            default:                                           instr_known = 1'b0;
        endcase
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] instret_r;
    logic             decode_bad_s;
    logic             retire_s;

    assign decode_bad_s = ~instr_known(op, funct);
    assign instret      = instret_r;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Retired-instruction counter; wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            instret_r <= '0;
        end else if (retire_s) begin
            instret_r <= instret_r + CNT_ONE;
        end else begin
            instret_r <= instret_r;
        end
    end

    // Terminal states retire the instruction on the edge leaving them.
    always_comb begin
        retire_s = 1'b0;
        case (state_r)
            S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_BLE, S_IMMWB, S_JUMP: retire_s = 1'b1;
            default:                                                  retire_s = 1'b0;
        endcase
    end

    // Next-state logic; unknown encodings fall back to FETCH.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH: state_next_s = S_DECODE;
            S_DECODE: begin
                if (decode_bad_s) begin
                    state_next_s = S_FETCH;
                end else begin
                    case (op)
                        OP_LW, OP_SW: state_next_s = S_MEMADR;
                        OP_RTYPE:     state_next_s = S_EXECUTE;
                        OP_BEQ:       state_next_s = S_BEQ;
                        OP_BLE:       state_next_s = S_BLE;
                        OP_ADDI:      state_next_s = S_ADDIEX;
                        OP_LI:        state_next_s = S_LIEX;
                        OP_J:         state_next_s = S_JUMP;
                        default:      state_next_s = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: begin
                if (op == OP_SW) begin
                    state_next_s = S_MEMWR;
                end else begin
                    state_next_s = S_MEMRD;
                end
            end
            S_MEMRD:          state_next_s = S_MEMWB;
            S_EXECUTE:        state_next_s = S_ALUWB;
            S_ADDIEX, S_LIEX: state_next_s = S_IMMWB;
            default:          state_next_s = S_FETCH;
        endcase
    end

    // Moore output decode; reset forces every enable low immediately.
    always_comb begin
        pcen       = 1'b0;
        irwrite    = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        illegal    = 1'b0;
        if (!reset) begin
            pcen       = 1'b0;
            irwrite    = 1'b0;
            memwrite   = 1'b0;
            regwrite   = 1'b0;
            illegal    = 1'b0;
            alucontrol = ALU_ADD;
        end else begin
            case (state_r)
                S_FETCH: begin
                    alusrcb = 2'b01;
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    illegal = decode_bad_s;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    iord = 1'b1;
                end
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b00;
                    alucontrol = funct_alu(funct);
                end
                S_ALUWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BEQ: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    pcen       = zero;
                end
                S_BLE: begin
                    alusrca    = 1'b1;
                    alucontrol = ALU_SUB;
                    pcsrc      = 2'b01;
                    pcen       = zero | sign;
                end
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_LIEX: begin
                    alusrca    = 1'b1;
                    alusrcb    = 2'b10;
                    alucontrol = ALU_LI;
                end
                S_IMMWB: begin
                    regwrite = 1'b1;
                end
                S_JUMP: begin
                    pcsrc = 2'b10;
                    pcen  = 1'b1;
                end
                default: begin
                    alucontrol = ALU_ADD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-cycle expected outputs are queued by
// the stimulus process and popped by a negedge monitor.
module tb_mc_controller;

    localparam int CW = 4;

    typedef struct packed {
        logic       pcen;
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [2:0] alucontrol;
        logic       illegal;
    } outs_t;

    typedef struct {
        outs_t         o;
        logic [CW-1:0] cnt;
        string         tag;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [5:0]    op = 6'd0;
    logic [5:0]    funct = 6'd0;
    logic          zero = 1'b0;
    logic          sign = 1'b0;
    logic          pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca, illegal;
    logic [1:0]    alusrcb, pcsrc;
    logic [2:0]    alucontrol;
    logic [CW-1:0] instret;
    outs_t         dut_o;

    int total = 0;
    int bad = 0;
    exp_t exp_q[$];
    logic [CW-1:0] cnt_m = '0;

    mc_controller #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .sign(sign),
        .pcen(pcen), .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal),
        .instret(instret)
    );

    assign dut_o = {pcen, irwrite, memwrite, regwrite, iord, memtoreg, regdst, alusrca,
                    alusrcb, pcsrc, alucontrol, illegal};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, "_outs"}, 32'(dut_o), 32'(e.o));
            chk({e.tag, "_instret"}, 32'(instret), 32'(e.cnt));
        end
    end

    function automatic outs_t idle();
        outs_t o;
        o = '0;
        o.alucontrol = 3'b010;
        return o;
    endfunction

    function automatic logic [3:0] funct_alu(input logic [5:0] f);
        // bit 3 set means the funct is not a known R-type operation
        case (f)
            6'b100000: return 4'b0010;
            6'b100010: return 4'b0110;
            6'b100100: return 4'b0000;
            6'b100101: return 4'b0001;
            6'b101010: return 4'b0111;
            6'b000000: return 4'b0011;
            6'b000101: return 4'b0100;
            default:   return 4'b1000;
        endcase
    endfunction

    // Reference model: list of per-cycle outputs for one instruction.
    // keep > 0 truncates the list (instruction abandoned by reset).
    task automatic run_instr(input logic [5:0] o_op, input logic [5:0] o_fn,
                             input logic z, input logic s, input int keep, input string tag);
        outs_t seq[$];
        outs_t o;
        logic  legal;
        logic [3:0] fa;
        int n;
        op = o_op; funct = o_fn; zero = z; sign = s;
        o = idle(); o.pcen = 1'b1; o.irwrite = 1'b1; o.alusrcb = 2'b01; seq.push_back(o);
        o = idle(); o.alusrcb = 2'b11; seq.push_back(o);
        legal = 1'b1;
        fa = funct_alu(o_fn);
        case (o_op)
            6'b100011: begin
                o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10; seq.push_back(o);
                o = idle(); o.iord = 1'b1; seq.push_back(o);
                o = idle(); o.memtoreg = 1'b1; o.regwrite = 1'b1; seq.push_back(o);
            end
            6'b101011: begin
                o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10; seq.push_back(o);
                o = idle(); o.iord = 1'b1; o.memwrite = 1'b1; seq.push_back(o);
            end
            6'b000000: begin
                if (fa[3]) begin
                    legal = 1'b0;
                end else begin
                    o = idle(); o.alusrca = 1'b1; o.alucontrol = fa[2:0]; seq.push_back(o);
                    o = idle(); o.regdst = 1'b1; o.regwrite = 1'b1; seq.push_back(o);
                end
            end
            6'b000100, 6'b000110: begin
                o = idle(); o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01;
                o.pcen = (o_op == 6'b000100) ? z : (z | s);
                seq.push_back(o);
            end
            6'b001000, 6'b011000: begin
                o = idle(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
                if (o_op == 6'b011000) o.alucontrol = 3'b101;
                seq.push_back(o);
                o = idle(); o.regwrite = 1'b1; seq.push_back(o);
            end
            6'b000010: begin
                o = idle(); o.pcsrc = 2'b10; o.pcen = 1'b1; seq.push_back(o);
            end
            default: legal = 1'b0;
        endcase
        if (!legal) seq[1].illegal = 1'b1;
        n = (keep > 0 && keep < seq.size()) ? keep : seq.size();
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.o = seq[i];
            e.cnt = cnt_m;
            e.tag = $sformatf("%s_c%0d", tag, i);
            exp_q.push_back(e);
        end
        repeat (n) @(posedge clk);
        #1;
        if (legal && n == seq.size()) cnt_m = cnt_m + 1'b1;
    endtask

    logic [5:0] op_tab[8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                              6'b000110, 6'b001000, 6'b011000, 6'b000010};
    logic [5:0] fn_tab[7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                              6'b101010, 6'b000000, 6'b000101};

    initial begin
        logic [5:0] rop, rfn;
        // Reset held three cycles; enables must stay low.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_enables", {28'd0, pcen, irwrite, memwrite, regwrite}, 32'd0);
            chk("rst_alu", 32'(alucontrol), 32'd2);
            chk("rst_instret", 32'(instret), 32'd0);
        end
        reset = 1'b1;

        run_instr(6'b100011, 6'd0, 1'b0, 1'b0, 0, "lw");
        run_instr(6'b000000, 6'b000000, 1'b0, 1'b0, 0, "sll");
        run_instr(6'b000000, 6'b000101, 1'b0, 1'b0, 0, "zfr");
        run_instr(6'b000110, 6'd3, 1'b0, 1'b0, 0, "ble00");
        run_instr(6'b000110, 6'd3, 1'b0, 1'b1, 0, "ble01");
        run_instr(6'b000110, 6'd3, 1'b1, 1'b0, 0, "ble10");
        run_instr(6'b011000, 6'd9, 1'b0, 1'b0, 0, "li");
        run_instr(6'b111111, 6'd0, 1'b0, 1'b0, 0, "ill_op");
        run_instr(6'b000000, 6'b111111, 1'b0, 1'b0, 0, "ill_fn");

        // sw abandoned by reset during its MEMWR cycle.
        run_instr(6'b101011, 6'd0, 1'b0, 1'b0, 3, "sw_abort");
        chk("memwr_before_rst", 32'(memwrite), 32'd1);
        reset = 1'b0;
        #1;
        chk("memwr_in_rst", {29'd0, memwrite, pcen, regwrite}, 32'd0);
        @(posedge clk); #1;
        chk("abort_instret", 32'(instret), 32'd0);
        chk("abort_irwrite", 32'(irwrite), 32'd0);
        reset = 1'b1;
        cnt_m = '0;

        // Sixteen jumps bring the counter to all ones and then wrap it.
        for (int i = 0; i < 15; i++) run_instr(6'b000010, 6'd0, 1'b0, 1'b0, 0, "j");
        chk("cnt_all_ones", 32'(instret), 32'd15);
        run_instr(6'b000010, 6'd0, 1'b0, 1'b0, 0, "j_wrap");
        chk("cnt_wrap", 32'(instret), 32'd0);

        for (int i = 0; i < 250; i++) begin
            int pick;
            pick = $urandom_range(0, 9);
            rop = (pick < 8) ? op_tab[pick] : 6'($urandom);
            rfn = ($urandom_range(0, 5) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 6)];
            run_instr(rop, rfn, 1'($urandom), 1'($urandom), 0, "rnd");
        end
        @(posedge clk); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
